// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shared definitions for the ALU shift/rotate register.
//   - OP_* : 3-bit operation codes carried on shift_reg_unit.op
//   - state_e : controller FSM states
//   - cell_sel_e : per-bit source select for shift_cell
//   - is_shift_op() : true for the ops that take the multi-cycle shift path
package alu_shift_pkg;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ASR  = 3'd3;
   localparam logic [2:0] OP_ROL  = 3'd4;
   localparam logic [2:0] OP_ROR  = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   // LEFT is the higher-index neighbour, RIGHT the lower-index neighbour.
   typedef enum logic [2:0] {
      CELL_HOLD  = 3'd0,
      CELL_LOAD  = 3'd1,
      CELL_LEFT  = 3'd2,
      CELL_RIGHT = 3'd3,
      CELL_ZERO  = 3'd4
   } cell_sel_e;

   function automatic logic is_shift_op(input logic [2:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_cell.sv
// shift_cell: one bit of the shift register, a 5-way source mux feeding a flip-flop.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset to 0
//   i_sel     : source select (hold, parallel in, left/right neighbour, zero)
//   i_pin     : parallel-load data bit
//   i_left    : higher-index neighbour (or boundary source at the MSB)
//   i_right   : lower-index neighbour (or boundary source at bit 0)
//   o_q       : stored bit
module shift_cell
   import alu_shift_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  cell_sel_e i_sel,
   input  logic      i_pin,
   input  logic      i_left,
   input  logic      i_right,
   output logic      o_q
);

   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 1'b0;
      end else begin
         unique case (i_sel)
            CELL_HOLD:  r_q <= r_q;
            CELL_LOAD:  r_q <= i_pin;
            CELL_LEFT:  r_q <= i_left;
            CELL_RIGHT: r_q <= i_right;
            CELL_ZERO:  r_q <= 1'b0;
            default:    r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/shift_reg_unit.sv
// shift_reg_unit: WIDTH-bit load/clear/shift/rotate register, one bit position per clock,
// sequenced by a start/busy/done handshake. WIDTH must be at least 2.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : operation request, only sampled while idle
//   op       : operation code (alu_shift_pkg OP_*), captured with start
//   shamt    : shift count, captured with start
//   din      : operand, captured with start
//   sin      : serial input for SHL/SHR, sampled on every shift cycle
//   q        : register contents
//   cout     : last bit shifted or rotated out
//   busy     : high while an operation is in progress (RUN or FIN)
//   done     : one-cycle completion pulse (FIN)
module shift_reg_unit
   import alu_shift_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   state_e           r_state;
   logic [2:0]       r_op;
   logic [SHW-1:0]   r_cnt;
   logic             r_cout;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_left_nb;
   logic [WIDTH-1:0] w_right_nb;
   cell_sel_e        w_sel;
   logic             w_dir_left;
   logic             w_lsb_in;
   logic             w_msb_in;

   // Left-moving ops take data from the lower neighbour; the rest move right.
   assign w_dir_left = (r_op == OP_SHL) || (r_op == OP_ROL);

   // Boundary sources: bit 0 is fed on left moves, the MSB on right moves.
   always_comb begin
      w_lsb_in = w_q[WIDTH-1];
      if (r_op == OP_SHL) begin
         w_lsb_in = sin;
      end
      w_msb_in = w_q[WIDTH-1];
      unique case (r_op)
         OP_SHR:  w_msb_in = sin;
         OP_ROR:  w_msb_in = w_q[0];
         default: w_msb_in = w_q[WIDTH-1];
      endcase
   end

   assign w_left_nb  = {w_msb_in, w_q[WIDTH-1:1]};
   assign w_right_nb = {w_q[WIDTH-2:0], w_lsb_in};

   // One select drives every cell; the whole word moves together.
   always_comb begin
      w_sel = CELL_HOLD;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               unique case (op)
                  OP_NOP:  w_sel = CELL_HOLD;
                  OP_CLR:  w_sel = CELL_ZERO;
                  default: w_sel = CELL_LOAD;
               endcase
            end
         end
         S_RUN:   w_sel = w_dir_left ? CELL_RIGHT : CELL_LEFT;
         S_FIN:   w_sel = CELL_HOLD;
         default: w_sel = CELL_HOLD;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      shift_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .i_sel   (w_sel),
         .i_pin   (din[i]),
         .i_left  (w_left_nb[i]),
         .i_right (w_right_nb[i]),
         .o_q     (w_q[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_NOP;
         r_cnt   <= '0;
         r_cout  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_cout <= 1'b0;
                  if (is_shift_op(op) && (shamt != '0)) begin
                     r_cnt   <= shamt;
                     r_state <= S_RUN;
                  end else begin
                     r_state <= S_FIN;
                  end
               end
            end
            S_RUN: begin
               // Outgoing bit is the one leaving the word; for rotates it is also the wrapped bit.
               r_cout <= w_dir_left ? w_q[WIDTH-1] : w_q[0];
               r_cnt  <= r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  r_state <= S_FIN;
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign q    = w_q;
   assign cout = r_cout;
   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_shift_reg_unit.sv
module tb_shift_reg_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [2:0]   shamt;
   logic [W-1:0] din;
   logic         sin;
   logic [W-1:0] q;
   logic         cout;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] model_q;

   shift_reg_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .shamt (shamt),
      .din   (din),
      .sin   (sin),
      .q     (q),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [2:0]   sh;
      logic [W-1:0] din;
      logic [W-1:0] sv;   // sv[k] is sin for the k-th shift
      logic [W-1:0] eq;
      logic         ec;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the operand, with serial-in bits placed where
   // the k-th of n single-bit shifts would leave them.
   function automatic void model(input logic [2:0] o, input logic [2:0] n, input logic [W-1:0] d,
                                 input logic [W-1:0] sv, input logic [W-1:0] prev,
                                 output logic [W-1:0] rq, output logic rc);
      int nn;
      logic [2*W-1:0] t;
      nn = int'(n);
      rc = 1'b0;
      rq = prev;
      case (o)
         3'd0: rq = d;
         3'd6: rq = '0;
         3'd7: rq = prev;
         3'd1: begin
            rq = W'(d << nn);
            for (int k = 0; k < nn; k++) rq[nn-1-k] = sv[k];
            if (nn > 0) rc = d[W-nn];
         end
         3'd2: begin
            rq = d >> nn;
            for (int k = 0; k < nn; k++) rq[W-nn+k] = sv[k];
            if (nn > 0) rc = d[nn-1];
         end
         3'd3: begin
            rq = W'($signed(d) >>> nn);
            if (nn > 0) rc = d[nn-1];
         end
         3'd4: begin
            t  = {d, d} << nn;
            rq = t[2*W-1:W];
            if (nn > 0) rc = rq[0];
         end
         default: begin
            t  = {d, d} >> nn;
            rq = t[W-1:0];
            if (nn > 0) rc = rq[W-1];
         end
      endcase
   endfunction

   // Called just after a negedge with the unit idle; returns at the negedge of cycle n+2.
   task automatic run_op(input logic [2:0] o, input logic [2:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] sv, input logic [W-1:0] eq, input logic ec,
                         input string nm);
      int nn;
      nn    = ((o >= 3'd1) && (o <= 3'd5)) ? int'(n) : 0;
      start = 1'b1;
      op    = o;
      shamt = n;
      din   = d;
      sin   = 1'b0;
      for (int c = 1; c <= nn + 1; c++) begin
         @(negedge clk);
         start = 1'b0;
         op    = 3'($urandom);
         shamt = 3'($urandom);
         din   = W'($urandom);
         sin   = (c <= nn) ? sv[c-1] : 1'b0;
         chk($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'd1);
         chk($sformatf("%s done c%0d", nm, c), 32'(done), (c == nn + 1) ? 32'd1 : 32'd0);
         if (c == 1 && nn > 0) chk($sformatf("%s q@c1", nm), 32'(q), 32'(d));
         if (c == nn + 1) begin
            chk($sformatf("%s q", nm), 32'(q), 32'(eq));
            chk($sformatf("%s cout", nm), 32'(cout), 32'(ec));
         end
      end
      @(negedge clk);
      chk($sformatf("%s idle busy", nm), 32'(busy), 32'd0);
      chk($sformatf("%s idle done", nm), 32'(done), 32'd0);
   endtask

   initial begin
      int dn;
      logic [2:0]   ro, rs;
      logic [W-1:0] rd, rv, eq;
      logic         ec;

      //          op    sh    din    sv     eq     ec
      vecs[0]  = '{3'd0, 3'd0, 8'hA5, 8'h00, 8'hA5, 1'b0};
      vecs[1]  = '{3'd1, 3'd3, 8'h81, 8'h00, 8'h08, 1'b0};
      vecs[2]  = '{3'd1, 3'd3, 8'h81, 8'hFF, 8'h0F, 1'b0};
      vecs[3]  = '{3'd3, 3'd2, 8'h80, 8'h00, 8'hE0, 1'b0};
      vecs[4]  = '{3'd2, 3'd2, 8'h03, 8'h00, 8'h00, 1'b1};
      vecs[5]  = '{3'd5, 3'd1, 8'h01, 8'h00, 8'h80, 1'b1};
      vecs[6]  = '{3'd4, 3'd7, 8'h80, 8'h00, 8'h40, 1'b0};
      vecs[7]  = '{3'd2, 3'd0, 8'h5A, 8'hFF, 8'h5A, 1'b0};
      vecs[8]  = '{3'd6, 3'd3, 8'hFF, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{3'd7, 3'd4, 8'hFF, 8'h00, 8'h00, 1'b0};
      vecs[10] = '{3'd2, 3'd4, 8'hF0, 8'h0A, 8'hAF, 1'b0};
      vecs[11] = '{3'd4, 3'd3, 8'h96, 8'h00, 8'hB4, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      shamt = 3'd0;
      din   = '0;
      sin   = 1'b0;
      #12;
      chk("reset q", 32'(q), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].sh, vecs[i].din, vecs[i].sv, vecs[i].eq, vecs[i].ec,
                $sformatf("vec%0d", i));
      end
      model_q = 8'hB4;

      // Second start during RUN must be ignored.
      start = 1'b1; op = 3'd1; shamt = 3'd3; din = 8'h81; sin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 3'd0; din = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      dn = 0;
      for (int c = 0; c < 10; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("ignored start done count", 32'(dn), 32'd1);
      chk("ignored start q", 32'(q), 32'h08);
      chk("ignored start busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of a rotate.
      start = 1'b1; op = 3'd4; shamt = 3'd5; din = 8'h81;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-abort busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort q", 32'(q), 32'd0);
      chk("abort cout", 32'(cout), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      chk("abort no done", 32'(dn), 32'd0);
      run_op(3'd0, 3'd0, 8'h3C, 8'h00, 8'h3C, 1'b0, "post-abort load");
      model_q = 8'h3C;

      // Random ops back to back, live sin, against the arithmetic model.
      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom_range(0, 7));
         rs = 3'($urandom_range(0, 7));
         rd = W'($urandom);
         rv = W'($urandom);
         model(ro, rs, rd, rv, model_q, eq, ec);
         run_op(ro, rs, rd, rv, eq, ec, $sformatf("rand%0d op%0d sh%0d din%0h", i, ro, rs, rd));
         model_q = eq;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_reg_unit.md
# shift_reg_unit

Parametrised multi-cycle shift/rotate register for the ALU datapath. It replaces single-bit storage cells with a WIDTH-bit register that supports parallel load, clear, logical and arithmetic shifts, and rotates. A start/busy/done handshake sequences the operation at one bit position per clock. It feeds the ALU result mux and the carry flag logic.

## Interface
Parameters:
- WIDTH, 8, register width in bits; must be at least 2.
- SHW, $clog2(WIDTH), width of the shift amount; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  operation request; sampled only in IDLE.
- op  in  3  operation code, captured with start.
- shamt  in  SHW  shift count, 0..WIDTH-1, captured with start.
- din  in  WIDTH  operand, captured with start.
- sin  in  1  serial input for SHL/SHR; sampled on every shift cycle.
- q  out  WIDTH  register contents.
- cout  out  1  last bit shifted or rotated out.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; high exactly when state == FIN.

## Operation
Op codes:
- 0 LOAD
- 1 SHL: sin enters bit 0
- 2 SHR: sin enters MSB
- 3 ASR: MSB replicated
- 4 ROL
- 5 ROR
- 6 CLR
- 7 NOP

Reset:
- q=0, cout=0, busy=0, done=0, state=IDLE, internal count=0.
- Reset is asynchronous: it aborts any operation in progress immediately, and no done is generated for the aborted operation.

FSM states are IDLE, RUN and FIN.
- IDLE, start=1: capture op and shamt; clear cout.
  - LOAD and ops 1-5: q<=din.
  - CLR: q<=0.
  - NOP: q unchanged.
  - Ops 1-5 with shamt!=0: go to RUN with count=shamt.
  - All other cases: go to FIN.
- IDLE, start=0: hold all state.
- RUN, each cycle: shift q by one position according to op; cout<=outgoing bit; count<=count-1. When count==1, go to FIN.
  - SHL: outgoing bit is q[WIDTH-1].
  - SHR/ASR: outgoing bit is q[0].
  - ROL: q[WIDTH-1] wraps into bit 0.
  - ROR: q[0] wraps into MSB.
  - Rotates take cout equal to the wrapped bit.
- FIN: done=1; q and cout hold; go to IDLE unconditionally.
- start while busy=1 (RUN or FIN) is ignored; there is no queueing.
- op, shamt and din are don't-care after the accept cycle.
- sin is live: a change during RUN affects the remaining shifts.
- shamt uses modular width SHW, so shamt>=WIDTH cannot be expressed. Count decrements never underflow because RUN is entered only with count>=1.

## Timing
- Start sampled high in cycle 0: busy=1 from cycle 1 through cycle n+1, where n=shamt for ops 1-5 and n=0 otherwise.
- q holds the final result and done=1 in cycle n+1.
- For ops 1-5 with n>0, q=din during cycle 1, and one shift is applied at the end of each of cycles 1..n.
- The next start is accepted in cycle n+2 at the earliest. Back-to-back throughput is n+2 cycles per operation.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package alu_shift_pkg holds:
  - op-code localparams OP_LOAD..OP_NOP (3 bits);
  - FSM state encoding S_IDLE, S_RUN, S_FIN (2 bits).
- One sub-module, shift_cell: a per-bit mux-plus-flip-flop with asynchronous active-high reset to 0.
  - Selects among hold, parallel in, left neighbour, right neighbour and zero.
  - Instantiated WIDTH times with a generate loop; boundary neighbours are driven by sin, the MSB, or the wrap bit according to op.
- The top level contains the FSM, the down-counter, cout and neighbour-source selection.

## Test plan (WIDTH=8)
- LOAD din=0xA5 -> q=0xA5 and done=1 in cycle 1; busy low by cycle 2; cout=0.
- SHL shamt=3, din=0x81, sin=0 -> q=0x08, cout=0, done in cycle 4. Repeat with sin=1 -> q=0x0F.
- ASR shamt=2, din=0x80 -> q=0xE0, cout=0, done in cycle 3. SHR shamt=2, din=0x03, sin=0 -> q=0x00, cout=1.
- ROR shamt=1, din=0x01 -> q=0x80, cout=1, done in cycle 2. ROL shamt=7, din=0x80 -> q=0x40, cout=0, done in cycle 8.
- SHR shamt=0, din=0x5A -> q=0x5A, done in cycle 1. CLR -> q=0x00 in cycle 1. A second start pulsed during RUN -> ignored; q and the done count match a single operation.
- rst asserted mid-RUN of ROL shamt=5 -> q=0, cout=0, busy=0 immediately with no done pulse. A new LOAD after rst deasserts completes normally.
